// File: rtl/alu_result_queue_if.sv
// Handshake bundle between the ALU producer, the result queue and the
// write-back/display consumer. The queue takes the slave view; the block
// that feeds results and accepts them takes the master view.
interface alu_result_queue_if #(
  parameter int WIDTH = 20,
  parameter int PTR_W = 2
);
  logic             inValid;
  logic [WIDTH-1:0] inResult;
  logic [1:0]       inSelect;
  logic             inReady;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outResult;
  logic [1:0]       outSelect;
  logic             outZero;
  logic             outNegative;
  logic [PTR_W:0]   count;

  modport master (
    output inValid, inResult, inSelect, outReady,
    input  inReady, outValid, outResult, outSelect, outZero, outNegative, count
  );

  modport slave (
    input  inValid, inResult, inSelect, outReady,
    output inReady, outValid, outResult, outSelect, outZero, outNegative, count
  );
endinterface

// File: rtl/alu_result_queue.sv
// Circular FIFO that buffers 20-bit ALU results with their aluSelect code
// and presents them to a consumer over valid/ready. Zero/negative flags
// are derived from the head entry, not stored.
// Optional macro ALU_RESULT_BYPASS_EN: when the queue is empty, an incoming
// result is forwarded combinationally and, if taken that cycle, never stored.
module alu_result_queue #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  alu_result_queue_if.slave q
);

  typedef struct packed {
    logic [1:0]       sel;
    logic [WIDTH-1:0] result;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic   full, empty;
  logic   push_fire, pop_fire;
  logic   bypass_take;
  entry_t in_entry, head, out_entry;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign in_entry = '{sel: q.inSelect, result: q.inResult};
  assign head     = mem_q[rd_ptr_q];

`ifdef ALU_RESULT_BYPASS_EN
  // Empty queue forwards the producer straight to the consumer.
  assign bypass_take = empty && q.inValid && q.outReady;
  assign out_entry   = (empty && q.inValid) ? in_entry : head;
  assign q.outValid  = !empty || q.inValid;
`else
  assign bypass_take = 1'b0;
  assign out_entry   = head;
  assign q.outValid  = !empty;
`endif

  // A transaction completed through the bypass must not also be stored.
  assign push_fire = q.inValid && !full && !bypass_take;
  assign pop_fire  = !empty && q.outReady;

  assign q.inReady     = !full;
  assign q.outResult   = out_entry.result;
  assign q.outSelect   = out_entry.sel;
  assign q.outZero     = (out_entry.result == '0);
  assign q.outNegative = out_entry.result[WIDTH-1];
  assign q.count       = count_q;

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset may land mid-operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the write pointer on a push.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; occupancy alone defines which entries are live.
    if (push_fire) mem_q[wr_ptr_q] <= in_entry;
  end

endmodule

// File: tb/tb_alu_result_queue.sv
// Self-checking bench for alu_result_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_alu_result_queue;
  localparam int WIDTH = 20;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
`ifdef ALU_RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_result_queue_if #(.WIDTH(WIDTH), .PTR_W(PTR_W)) bus ();

  alu_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk  (clk),
    .reset(reset),
    .q    (bus.slave)
  );

  typedef struct {
    logic [1:0]       sel;
    logic [WIDTH-1:0] res;
  } ent_t;

  ent_t model[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] r, input logic [1:0] s, input bit rdy);
    bus.inValid  = v;
    bus.inResult = r;
    bus.inSelect = s;
    bus.outReady = rdy;
  endtask

  // Compare every output with what the model says the queue should show.
  task automatic check_state(input string tag);
    bit   exp_valid;
    ent_t h;
    h = '{sel: 2'b00, res: '0};
    exp_valid = (model.size() > 0) || (BYP && bus.inValid);
    if (model.size() > 0) h = model[0];
    else if (BYP && bus.inValid) h = '{sel: bus.inSelect, res: bus.inResult};
    check({tag, "_count"}, 32'(bus.count), 32'(model.size()));
    check({tag, "_inReady"}, 32'(bus.inReady), 32'(model.size() < DEPTH));
    check({tag, "_outValid"}, 32'(bus.outValid), 32'(exp_valid));
    if (exp_valid) begin
      check({tag, "_result"}, 32'(bus.outResult), 32'(h.res));
      check({tag, "_select"}, 32'(bus.outSelect), 32'(h.sel));
      check({tag, "_zero"}, 32'(bus.outZero), 32'(h.res == 0));
      check({tag, "_neg"}, 32'(bus.outNegative), 32'(h.res[WIDTH-1]));
    end
  endtask

  // One clock: decide what the queue must do from current inputs, advance, check.
  task automatic tick(input string tag);
    bit   byp_take, push, pop;
    ent_t e;
    byp_take = BYP && (model.size() == 0) && bus.inValid && bus.outReady;
    push     = bus.inValid && (model.size() < DEPTH) && !byp_take;
    pop      = (model.size() > 0) && bus.outReady;
    e        = '{sel: bus.inSelect, res: bus.inResult};
    @(posedge clk);
    if (pop)  void'(model.pop_front());
    if (push) model.push_back(e);
    #1;
    check_state(tag);
  endtask

  task automatic drain();
    drive(0, '0, 2'b00, 1);
    for (int i = 0; i < DEPTH + 1; i++) tick("drain");
  endtask

  initial begin
    drive(0, '0, 2'b00, 0);
    reset = 1'b1;
    #3;
    check_state("reset");
    #9 reset = 1'b0;

    // Single push becomes visible one cycle later.
    drive(1, 20'h00005, 2'b01, 0);
    tick("push1");
    check("push1_res", 32'(bus.outResult), 32'h00005);
    check("push1_zero", 32'(bus.outZero), 32'd0);
    drive(0, '0, 2'b00, 0);
    drain();

    // Zero and negative flags on consecutive entries.
    drive(1, 20'h00000, 2'b10, 0);
    tick("pushz");
    drive(1, 20'h80000, 2'b11, 0);
    tick("pushn");
    check("flag_zero", 32'(bus.outZero), 32'd1);
    drive(0, '0, 2'b00, 1);
    tick("pop_z");
    check("flag_neg", 32'(bus.outNegative), 32'd1);
    check("flag_nz", 32'(bus.outZero), 32'd0);
    tick("pop_n");
    check("empty_valid", 32'(bus.outValid), 32'd0);

    // Overflow: fifth push is refused and the first four come out in order.
    for (int i = 1; i <= 5; i++) begin
      drive(1, WIDTH'(i), 2'(i), 0);
      tick("fill");
      if (i == 4) check("full_inReady", 32'(bus.inReady), 32'd0);
    end
    drive(0, '0, 2'b00, 1);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_order", 32'(bus.outResult), 32'(i));
      tick("ovf_pop");
    end

    // Steady-state push+pop with two entries resident.
    drive(1, 20'h0000A, 2'b00, 0);
    tick("pre_a");
    drive(1, 20'h0000B, 2'b01, 0);
    tick("pre_b");
    for (int i = 0; i < 10; i++) begin
      drive(1, WIDTH'(32'h10 + i), 2'(i), 1);
      tick("pushpop");
      check("pushpop_cnt", 32'(bus.count), 32'd2);
    end
    drain();

    // Asynchronous reset between edges takes effect immediately.
    for (int i = 0; i < 3; i++) begin
      drive(1, WIDTH'(32'h100 + i), 2'b01, 0);
      tick("pre_rst");
    end
    drive(0, '0, 2'b00, 0);
    #2 reset = 1'b1;
    #1;
    model.delete();
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_valid", 32'(bus.outValid), 32'd0);
    check("arst_ready", 32'(bus.inReady), 32'd1);
    #1 reset = 1'b0;
    drive(1, 20'hABCDE, 2'b10, 0);
    tick("post_rst");
    check("post_rst_res", 32'(bus.outResult), 32'hABCDE);
    drive(0, '0, 2'b00, 0);
    drain();

`ifdef ALU_RESULT_BYPASS_EN
    // Empty queue with a ready consumer completes the transfer in the same cycle.
    drive(1, 20'h12345, 2'b11, 1);
    #1;
    check("byp_valid", 32'(bus.outValid), 32'd1);
    check("byp_res", 32'(bus.outResult), 32'h12345);
    tick("byp");
    check("byp_count", 32'(bus.count), 32'd0);
    drive(0, '0, 2'b00, 0);
`endif

    // Random traffic, alternating producer-heavy and consumer-heavy phases.
    for (int i = 0; i < 400; i++) begin
      bit heavy_in;
      heavy_in = ((i / 50) % 2) == 0;
      drive($urandom_range(0, 99) < (heavy_in ? 75 : 35),
            WIDTH'($urandom),
            2'($urandom_range(0, 3)),
            $urandom_range(0, 99) < (heavy_in ? 35 : 75));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_queue.md
Name: alu_result_queue

Overview:
- Downstream stage of the 20-bit ALU: captures each ALU result together with its aluSelect code.
- Stores results in a small circular FIFO and presents them to the consumer (write-back/display logic) over a valid/ready handshake.
- Derives zero and negative flags per entry, and decouples the combinational ALU from a consumer that may stall.

Parameters:
- WIDTH, 20, data width; must match the ALU output width.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- inValid  input  1  a new ALU result is present on inResult.
- inResult  input  WIDTH  ALU result (outputALU).
- inSelect  input  2  aluSelect code that produced inResult.
- inReady  output  1  queue can accept data; equals !full.
- outValid  output  1  head entry is valid; equals !empty.
- outReady  input  1  consumer accepts the head entry.
- outResult  output  WIDTH  head entry data.
- outSelect  output  2  head entry opcode.
- outZero  output  1  head entry result == 0.
- outNegative  output  1  head entry result bit WIDTH-1.
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Storage: DEPTH entries of {select[1:0], result[WIDTH-1:0]}. Flags are computed combinationally from the head entry; they are not stored.
- Pointers: wrPtr and rdPtr are PTR_W bits wide and wrap modulo DEPTH. An occupancy counter tracks count; full = (count == DEPTH), empty = (count == 0).
- Push: occurs on a clock edge when inValid && inReady. The entry is written at wrPtr, then wrPtr increments.
- Pop: occurs on a clock edge when outValid && outReady, then rdPtr increments.
- Simultaneous push and pop:
  - Not full and not empty: both happen and count is unchanged.
  - Full: push is blocked because inReady=0, so only the pop occurs.
  - Empty: pop is blocked because outValid=0, so only the push occurs.
- Latency: a pushed result appears on outResult one cycle after the push edge (registered FIFO read path).
- Overflow: inValid while full does not write and does not corrupt any entry. The producer must hold the data until inReady is high.
- Underflow: outReady while empty has no effect. outResult/outSelect hold the value of the stale rdPtr entry; this value is don't-care but must be stable.
- Reset (asynchronous, may assert mid-operation): wrPtr=0, rdPtr=0, count=0, hence outValid=0 and inReady=1. Storage array contents are not reset. In the reset state outResult/outSelect show entry 0, treated as don't-care, and outZero/outNegative follow those bits.
- Data ordering is strictly first-in, first-out.
- No combinational path from inValid to outValid, or from outReady to inReady, unless the optional feature is enabled.
- The state machine is implicit in count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
  - EMPTY → PARTIAL on push.
  - PARTIAL → FULL when a push occurs at count=DEPTH-1 with no pop.
  - FULL → PARTIAL on pop.
  - PARTIAL → EMPTY when a pop occurs at count=1 with no push.

Optional Feature:
- Macro: ALU_RESULT_BYPASS_EN.
- Defined: when empty and inValid, outValid=1 combinationally and outResult/outSelect/flags follow the inputs. If outReady is also high, the transaction completes in the same cycle: no write, pointers and count unchanged. If outReady is low, a normal push occurs.
- Undefined: no bypass; minimum latency is one cycle as stated above.

Test Plan:
- Reset, then push 0x00005 sel=01 with outReady=0 → next cycle: outValid=1, outResult=0x00005, outSelect=01, outZero=0, outNegative=0, count=1.
- Push 0x00000 then 0x80000 and pop both → first pop sees outZero=1; second pop sees outNegative=1, outZero=0; then count=0 and outValid=0.
- Push 5 values 0x1..0x5 with outReady=0 → inReady=0 after the 4th push; the 5th is not stored. Pops return 0x1, 0x2, 0x3, 0x4 in order.
- With count=2, push and pop in the same cycle for 10 cycles with values 0x10..0x19 → count stays 2 and outputs stay in FIFO order.
- Fill to count=3, assert reset asynchronously between clock edges → outValid=0, inReady=1, count=0 immediately, without waiting for a clock edge. Next push 0xABCDE is read back correctly.
- With ALU_RESULT_BYPASS_EN defined, queue empty, inValid=1, inResult=0x12345, outReady=1 → outValid=1 and outResult=0x12345 in the same cycle; count stays 0.
